// File: rtl/cell_core_sequencer.sv
// Cell-core program sequencer: fetches 16-bit instructions, drives an external
// combinational cell ALU and writes results back into a four-entry register file.
module cell_core_sequencer #(
    parameter int          REGISTER_LENGTH = 32,
    parameter int          PROG_ADDR_W     = 8,
    parameter logic [15:0] NOP_MASK        = 16'hF800
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [PROG_ADDR_W-1:0]     prog_len,
    input  logic                       init_valid,
    input  logic [REGISTER_LENGTH-1:0] init_value,
    output logic                       imem_req,
    output logic [PROG_ADDR_W-1:0]     imem_addr,
    input  logic                       imem_ack,
    input  logic [15:0]                imem_data,
    output logic [3:0]                 alu_opcode,
    output logic [7:0]                 alu_immediate,
    output logic [REGISTER_LENGTH-1:0] alu_a,
    output logic [REGISTER_LENGTH-1:0] alu_b,
    input  logic [REGISTER_LENGTH-1:0] alu_result,
    output logic                       busy,
    output logic                       done,
    output logic [REGISTER_LENGTH-1:0] cell_state
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    state_t                     state_q, state_d;
    logic [PROG_ADDR_W-1:0]     pc_q, pc_d;
    logic [15:0]                ir_q, ir_d;
    logic [REGISTER_LENGTH-1:0] r_q [4];
    logic [REGISTER_LENGTH-1:0] r_d [4];

    logic [3:0]             opcode;
    logic [1:0]             rd, rs, rt;
    logic [7:0]             imm;
    logic [PROG_ADDR_W-1:0] pc_inc;

    assign opcode     = ir_q[15:12];
    assign rd         = ir_q[11:10];
    assign rs         = ir_q[9:8];
    assign rt         = ir_q[7:6];
    assign imm        = ir_q[7:0];
    assign pc_inc     = pc_q + 1'b1;
    assign imem_addr  = pc_q;
    assign cell_state = r_q[0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        for (int i = 0; i < 4; i++) r_d[i] = r_q[i];
        imem_req      = 1'b0;
        alu_opcode    = '0;
        alu_immediate = '0;
        alu_a         = '0;
        alu_b         = '0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                // An init load and a start on the same edge both take effect.
                if (init_valid) r_d[0] = init_value;
                if (start) begin
                    if (prog_len != '0) begin
                        pc_d    = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_opcode    = opcode;
                alu_immediate = imm;
                alu_a         = r_q[rs];
                alu_b         = r_q[rt];
                if (!NOP_MASK[opcode]) r_d[rd] = alu_result;
                pc_d    = pc_inc;
                state_d = (pc_inc == prog_len) ? DONE : FETCH;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
        end
    end

endmodule

// File: tb/tb_cell_core_sequencer.sv
// Bench for cell_core_sequencer: attaches a small cell ALU and instruction memory,
// and checks cycle-by-cycle behaviour against an instruction-level reference model.
module tb_cell_core_sequencer;

    localparam int          RL   = 32;
    localparam int          AW   = 8;
    localparam logic [15:0] MASK = 16'hF800;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] prog_len;
    logic          init_valid;
    logic [RL-1:0] init_value;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_data;
    logic [3:0]    alu_opcode;
    logic [7:0]    alu_immediate;
    logic [RL-1:0] alu_a, alu_b, alu_result;
    logic          busy, done;
    logic [RL-1:0] cell_state;

    logic [15:0]   prog [256];
    logic [RL-1:0] mr [4];
    int            first_delay = 0;
    int            wait_cnt = 0;
    logic          stray_ack = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    cell_core_sequencer #(.REGISTER_LENGTH(RL), .PROG_ADDR_W(AW), .NOP_MASK(MASK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .init_valid(init_valid), .init_value(init_value),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_opcode(alu_opcode), .alu_immediate(alu_immediate), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy), .done(done), .cell_state(cell_state)
    );

    function automatic logic [RL-1:0] alu_fn(input logic [3:0] op, input logic [RL-1:0] a,
                                             input logic [RL-1:0] b, input logic [7:0] imm);
        logic [RL-1:0] s;
        s = {{(RL-8){imm[7]}}, imm};
        case (op)
            4'd0:    return s;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a ^ b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a + s;
            4'd7:    return a << imm[4:0];
            4'd8:    return a >> imm[4:0];
            4'd9:    return ~a;
            4'd10:   return a;
            default: return a + b + 32'h1234;
        endcase
    endfunction

    // Environment: combinational ALU and an instruction memory with a wait-state option.
    assign alu_result = alu_fn(alu_opcode, alu_a, alu_b, alu_immediate);
    assign imem_data  = imem_req ? prog[imem_addr] : 16'h6A5C;
    assign imem_ack   = stray_ack ||
                        (imem_req && wait_cnt >= ((imem_addr == '0) ? first_delay : 0));

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [RL-1:0] obs, input logic [RL-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_op"}, alu_opcode, 0);
        chk({tag, "_imm"}, alu_immediate, 0);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_cell"}, cell_state, 0);
    endtask

    // Runs prog[0..n-1] from the current negedge and checks every cycle up to return to idle.
    task automatic run(input int n, input int dly, input bit do_init, input logic [RL-1:0] ival,
                       input bit start_in_exec, input int abort_at);
        int op, rd, rs, rt, imm;
        first_delay = dly;
        prog_len    = AW'(n);
        start       = 1'b1;
        if (do_init) begin
            init_valid = 1'b1;
            init_value = ival;
            mr[0]      = ival;
        end
        @(negedge clk);
        start      = 1'b0;
        init_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w <= ((i == 0) ? dly : 0); w++) begin
                if (w > 0) @(negedge clk);
                chk("fetch_req", imem_req, 1);
                chk("fetch_addr", imem_addr, RL'(i));
                chk("fetch_busy", busy, 1);
                chk("fetch_aluop", {alu_opcode, alu_a[3:0]}, 0);
            end
            @(negedge clk);
            op  = int'(prog[i]) / 4096;
            rd  = (int'(prog[i]) / 1024) % 4;
            rs  = (int'(prog[i]) / 256) % 4;
            rt  = (int'(prog[i]) / 64) % 4;
            imm = int'(prog[i]) % 256;
            chk("exec_op", alu_opcode, RL'(op));
            chk("exec_imm", alu_immediate, RL'(imm));
            chk("exec_a", alu_a, mr[rs]);
            chk("exec_b", alu_b, mr[rt]);
            chk("exec_req", imem_req, 0);
            chk("exec_busy_done", {busy, done}, 2'b10);
            chk("exec_cell", cell_state, mr[0]);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_quiet("abort");
                for (int k = 0; k < 4; k++) mr[k] = '0;
                return;
            end
            if (start_in_exec && i == 0) start = 1'b1;
            stray_ack = 1'b1;
            if (((MASK >> op) & 16'd1) == 16'd0)
                mr[rd] = alu_fn(4'(op), mr[rs], mr[rt], 8'(imm));
            @(negedge clk);
            start     = 1'b0;
            stray_ack = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_req", imem_req, 0);
        @(negedge clk);
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("result_r0", cell_state, mr[0]);
    endtask

    initial begin
        int n;
        logic [RL-1:0] saved;
        rst_n = 1'b0; start = 1'b0; prog_len = '0; init_valid = 1'b0; init_value = '0;
        for (int k = 0; k < 256; k++) prog[k] = '0;
        for (int k = 0; k < 4; k++) mr[k] = '0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;

        // Init load while idle
        init_valid = 1'b1; init_value = 32'd5;
        @(negedge clk);
        init_valid = 1'b0;
        mr[0] = 32'd5;
        chk("init_cell", cell_state, 32'd5);
        chk("init_busy", busy, 0);

        // LI r1,3 ; ADD r0,r0,r1
        prog[0] = 16'h0403; prog[1] = 16'h1040;
        run(2, 0, 0, '0, 0, -1);
        chk("li_add_result", cell_state, 32'd8);

        // Same program, init coincident with start, three wait states on first fetch
        run(2, 3, 1, 32'd5, 0, -1);
        chk("delayed_result", cell_state, 32'd8);

        // Empty program
        saved = cell_state;
        start = 1'b1; prog_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_req", imem_req, 0);
        @(negedge clk);
        chk("empty_done_low", done, 0);
        chk("empty_cell", cell_state, saved);

        // LI r2,7 ; masked op 12 targeting r2 ; ADD r0,r2,r2 with start pulsed during EXEC
        prog[0] = 16'h0807; prog[1] = 16'hC8FF; prog[2] = 16'h1280;
        run(3, 0, 0, '0, 1, -1);
        chk("nop_result", cell_state, 32'd14);

        for (int t = 0; t < 20; t++) begin
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) prog[k] = 16'($urandom);
            run(n, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 0, -1);
        end

        // Asynchronous reset in the middle of a program, then immediate restart
        for (int k = 0; k < 4; k++) prog[k] = 16'($urandom);
        run(4, 1, 0, '0, 0, 1);
        @(negedge clk);
        chk_quiet("held_reset");
        rst_n = 1'b1;
        prog[0] = 16'h0403; prog[1] = 16'h1040;
        run(2, 0, 0, '0, 0, -1);
        chk("restart_result", cell_state, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
